imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the pipeline's fetch stage reads.
- Receives a framed byte stream over a valid/ready handshake and writes the payload into instruction memory through its write port, starting at address 0.
- Holds the processor in reset (cpu_hold) until a load completes with a good checksum.
- Sits between the host/debug byte link and instruction memory; cpu_hold is ORed into the processor reset.

Parameters:
- ADDR_W, 8, instruction memory address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1024, maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction memory write enable, one cycle per byte.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data (one instruction).
- cpu_hold  out  1  1 = processor held in reset.
- load_done  out  1  level; last frame loaded and checksum matched.
- load_error  out  1  level; last frame failed (zero length, checksum mismatch, timeout).

Behaviour:
- Frame format: SYNC_BYTE, then L (1..255), then L instruction bytes, then CSUM = sum of the L bytes mod 256.
- Handshake:
  - A byte is accepted on a rising clk edge where in_valid & in_ready.
  - in_ready is 0 while reset is low, and 1 at all other times; the loader never stalls.
- All outputs are registered.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0. State=IDLE. Internal count, checksum and timer are 0.
- States: IDLE, LEN, DATA, CSUM.
- IDLE:
  - A non-SYNC byte is discarded.
  - SYNC → LEN. On the next cycle: cpu_hold=1, load_done=0, load_error=0, timer=0.
- LEN:
  - L=0 → IDLE with load_error=1.
  - Otherwise: remaining=L, addr=0, csum=0 → DATA.
- DATA, per accepted byte b:
  - The following cycle: mem_we=1, mem_addr=addr, mem_wdata=b. Write latency is exactly 1 cycle after acceptance.
  - addr+1, csum+=b (8-bit wrap), remaining-1.
  - When remaining goes 1→0 → CSUM.
  - mem_we is 0 in every cycle not following an accepted DATA byte.
  - Back-to-back bytes give back-to-back write cycles.
- CSUM:
  - Byte == csum → IDLE, load_done=1, cpu_hold=0.
  - Mismatch → IDLE, load_error=1, cpu_hold stays 1.
  - Memory already written is not rolled back.
- SYNC inside a frame: in LEN, DATA or CSUM, SYNC_BYTE is treated as data. There is no escaping; the length field governs.
- Timeout:
  - In LEN, DATA or CSUM, the timer counts cycles with no accepted byte and clears on each accepted byte.
  - When the timer reaches TIMEOUT_CYC: → IDLE, load_error=1, cpu_hold=1.
  - The timer is frozen in IDLE.
- Reload:
  - A SYNC received after DONE or ERROR restarts a load.
  - cpu_hold re-asserts the cycle after SYNC is accepted, and both flags clear.
- load_done and load_error are never 1 simultaneously.
- Reset asserted mid-frame:
  - Immediately (asynchronously): mem_we=0, cpu_hold=1, flags=0, state=IDLE.
  - A partially written image remains in memory but the processor stays held.
- Address wrap: cannot occur, since L≤255 and addresses are 0..254. For ADDR_W<8, a write address wraps modulo 2^ADDR_W.

Test Plan:
- Good frame: after reset release, stream A5,03,40,81,C2,83 back-to-back. Required: writes (0,40),(1,81),(2,C2) on consecutive cycles, each one cycle after acceptance. One cycle after 83 is accepted: load_done=1, cpu_hold=0, load_error=0.
- Bad checksum: stream A5,02,10,20,31. Required: writes (0,10),(1,20) occur; then load_error=1, cpu_hold=1, load_done=0.
- Noise and zero length: stream 00,FF,A5,00. Required: no mem_we; load_error=1 after the 00 length byte; cpu_hold=1 throughout.
- Timeout: stream A5,04,11, then in_valid=0 for 1024 cycles. Required: single write (0,11); load_error=1 exactly at the 1024th idle cycle; a following full good frame then succeeds.
- Reload and SYNC-as-data: after a good load, stream A5,02,A5,01,A6. Required: cpu_hold=1 and load_done=0 the cycle after the first A5; writes (0,A5),(1,01); then load_done=1, cpu_hold=0.
- Async reset mid-DATA: drop reset between bytes of A5,03,40,81,.... Required: outputs take reset values without waiting for clk; after release the state is IDLE and a later 40 byte causes no write.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction-memory interface. Receives framed bytes
//   (SYNC_BYTE, L, L payload bytes, CSUM = sum of payload mod 256) and writes
//   the payload to instruction memory starting at address 0. The processor is
//   held in reset (cpu_hold) until a frame loads with a matching checksum.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   byte available on in_data
//   in_data    stream byte
//   in_ready   loader can accept a byte
//   mem_we     instruction memory write enable, one cycle per payload byte
//   mem_addr   write address
//   mem_wdata  write data
//   cpu_hold   1 = processor held in reset
//   load_done  level: last frame loaded and checksum matched
//   load_error level: last frame failed (zero length, bad checksum, timeout)
//   state_dbg  current FSM state (IDLE=0, LEN=1, DATA=2, CSUM=3)
//
// Handshake: a byte transfers on a rising clk edge where in_valid & in_ready
// are both 1. in_ready is 0 while reset is low and 1 otherwise (it rises on
// the first clock edge after reset release); the loader never stalls.

module imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        state_dbg
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  // Timeout fires on the edge that would take the timer to TIMEOUT_CYC.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;

  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         remaining_q;
  logic [7:0]         csum_q;
  logic [TIMER_W-1:0] timer_q;

  // Strobes from the next-state logic
  logic accept;
  logic start;      // SYNC accepted in IDLE
  logic load_len;   // nonzero length accepted
  logic wr;         // payload byte accepted
  logic ok;         // checksum matched
  logic fail;       // zero length, checksum mismatch or timeout
  logic timeout;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    load_len = 1'b0;
    wr       = 1'b0;
    ok       = 1'b0;
    fail     = 1'b0;
    timeout  = (state_q != IDLE) && !accept && (timer_q == TIMER_LAST);

    case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = LEN;
          start   = 1'b1;
        end
      end
      LEN: begin
        if (accept) begin
          if (in_data == 8'd0) begin
            state_d = IDLE;
            fail    = 1'b1;
          end else begin
            state_d  = DATA;
            load_len = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wr = 1'b1;
          if (remaining_q == 8'd1) state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = IDLE;
          if (in_data == csum_q) ok   = 1'b1;
          else                   fail = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
      fail    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= 8'd0;
      csum_q      <= 8'd0;
      timer_q     <= '0;
    end else begin
      in_ready_q <= 1'b1;
      mem_we_q   <= wr;

      if (load_len) begin
        remaining_q <= in_data;
        addr_q      <= '0;
        csum_q      <= 8'd0;
      end

      if (wr) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= in_data;
        addr_q      <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
        csum_q      <= csum_q + in_data;
        remaining_q <= remaining_q - 8'd1;
      end

      // Idle-gap timer: cleared by any accepted byte, held in IDLE.
      if (accept || timeout)      timer_q <= '0;
      else if (state_q != IDLE)   timer_q <= timer_q + 1'b1;

      if (start) begin
        cpu_hold_q <= 1'b1;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
      end
      if (ok) begin
        cpu_hold_q <= 1'b0;
        done_q     <= 1'b1;
      end
      if (fail) begin
        cpu_hold_q <= 1'b1;
        error_q    <= 1'b1;
        done_q     <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign state_dbg  = state_q;

endmodule
